// File: rtl/mining_job_loader_pkg.sv
// Shared definitions for the mining job loader: FSM state encoding, job
// geometry (payload bytes, nonce and hash widths) and the byte-counter helper
// used by the loader while it assembles a job.
package mining_job_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_MINE   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam int PAYLOAD_BYTES = 12;
    localparam int NONCE_W       = 32;
    localparam int HASH_W        = 24;
    localparam int PAYLOAD_W     = 8 * PAYLOAD_BYTES;
    localparam int BCNT_W        = 4;

    // True when the byte counter has passed every payload byte, i.e. the
    // next transfer is the target byte.
    function automatic logic is_target_byte(input logic [BCNT_W-1:0] bcnt);
        return (bcnt == BCNT_W'(PAYLOAD_BYTES));
    endfunction

endpackage

// File: rtl/mining_job_loader_watchdog.sv
// job_watchdog: cycle counter bounding how long a job may stay active.
// Ports:
//   clk, reset_L  clock and asynchronous active-low reset
//   clr_i         synchronous clear (takes priority over enable)
//   en_i          count one cycle
//   terminal_o    counter currently equals MAX_CYCLES-1
module job_watchdog #(
    parameter int MAX_CYCLES = 65535,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clr_i,
    input  logic en_i,
    output logic terminal_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal_o = (cnt_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/mining_job_loader.sv
// mining_job_loader: assembles a 12-byte payload plus a target byte from a
// byte stream, runs the nonce-search core, and returns the core's result (or
// a watchdog timeout) on a valid/ready result port.
// Ports:
//   in_data/in_valid/in_ready     job byte stream (payload MSB first, then target)
//   payload/target/active         drive the core; stable while active=1
//   terminado/nonce_in/hash_in    core completion and winning result
//   res_valid/res_ready           result handshake
//   res_nonce/res_hash/res_timeout result (zeros plus timeout flag on abort)
//   busy                          high in MINE or RESULT
module mining_job_loader
    import mining_job_loader_pkg::*;
#(
    parameter int MAX_CYCLES = 65535,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [7:0]           target,
    output logic                 active,
    input  logic                 terminado,
    input  logic [NONCE_W-1:0]   nonce_in,
    input  logic [HASH_W-1:0]    hash_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NONCE_W-1:0]   res_nonce,
    output logic [HASH_W-1:0]    res_hash,
    output logic                 res_timeout,
    output logic                 busy
);

    state_e               state_q,       state_d;
    logic [BCNT_W-1:0]    bcnt_q,        bcnt_d;
    logic [PAYLOAD_W-1:0] payload_q,     payload_d;
    logic [7:0]           target_q,      target_d;
    logic                 active_q,      active_d;
    logic                 guard_q,       guard_d;
    logic                 res_valid_q,   res_valid_d;
    logic [NONCE_W-1:0]   res_nonce_q,   res_nonce_d;
    logic [HASH_W-1:0]    res_hash_q,    res_hash_d;
    logic                 res_timeout_q, res_timeout_d;
    logic                 busy_q,        busy_d;
    logic                 wd_clr_s;
    logic                 wd_term_s;

    job_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk        (clk),
        .reset_L    (reset_L),
        .clr_i      (wd_clr_s),
        .en_i       (state_q == ST_MINE),
        .terminal_o (wd_term_s)
    );

    // Next-state logic: byte assembly, mining supervision and result handshake.
    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        payload_d     = payload_q;
        target_d      = target_q;
        active_d      = active_q;
        guard_d       = guard_q;
        res_valid_d   = res_valid_q;
        res_nonce_d   = res_nonce_q;
        res_hash_d    = res_hash_q;
        res_timeout_d = res_timeout_q;
        wd_clr_s      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (is_target_byte(bcnt_q)) begin
                        target_d = in_data;
                        bcnt_d   = {BCNT_W{1'b0}};
                        active_d = 1'b1;
                        guard_d  = 1'b1;
                        wd_clr_s = 1'b1;
                        state_d  = ST_MINE;
                    end else begin
                        payload_d = {payload_q[PAYLOAD_W-9:0], in_data};
                        bcnt_d    = bcnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_MINE: begin
                // The first MINE cycle may still see a flag left from the
                // previous search, so terminado only counts from the second.
                guard_d = 1'b0;
                if (!guard_q && terminado) begin
                    res_nonce_d   = nonce_in;
                    res_hash_d    = hash_in;
                    res_timeout_d = 1'b0;
                    active_d      = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = ST_RESULT;
                end else if (wd_term_s) begin
                    res_nonce_d   = {NONCE_W{1'b0}};
                    res_hash_d    = {HASH_W{1'b0}};
                    res_timeout_d = 1'b1;
                    active_d      = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = ST_RESULT;
                end else begin
                    state_d = ST_MINE;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                active_d    = 1'b0;
                res_valid_d = 1'b0;
                bcnt_d      = {BCNT_W{1'b0}};
                state_d     = ST_LOAD;
            end
        endcase
        busy_d = (state_d != ST_LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= ST_LOAD;
            bcnt_q        <= {BCNT_W{1'b0}};
            payload_q     <= {PAYLOAD_W{1'b0}};
            target_q      <= 8'h00;
            active_q      <= 1'b0;
            guard_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_nonce_q   <= {NONCE_W{1'b0}};
            res_hash_q    <= {HASH_W{1'b0}};
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            payload_q     <= payload_d;
            target_q      <= target_d;
            active_q      <= active_d;
            guard_q       <= guard_d;
            res_valid_q   <= res_valid_d;
            res_nonce_q   <= res_nonce_d;
            res_hash_q    <= res_hash_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign payload     = payload_q;
    assign target      = target_q;
    assign active      = active_q;
    assign res_valid   = res_valid_q;
    assign res_nonce   = res_nonce_q;
    assign res_hash    = res_hash_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;

endmodule
